// File: rtl/msg_schedule.sv
// SHA-256 message schedule expander: latches one 512-bit block and streams W0..W63,
// one word per advance strobe, using a 16-word rolling window.
module msg_schedule (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         load,
    input  logic [511:0] block_in,
    input  logic         advance,
    output logic [31:0]  w_out,
    output logic [5:0]   round_idx,
    output logic         w_valid,
    output logic         done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_r;
    logic [31:0] win_r [16];
    logic [5:0]  round_r;
    logic        w_valid_r;
    logic        done_r;
    logic [31:0] next_word_s;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b00_0000_0000, x[31:10]};
    endfunction

    // Next schedule word W[t+16] from the window holding W[t..t+15]
    always_comb begin
        next_word_s = 32'h0000_0000;
        next_word_s = sigma1(win_r[14]) + win_r[9] + sigma0(win_r[1]) + win_r[0];
    end

    // Control FSM, rolling window and registered outputs; load always takes priority
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r   <= ST_IDLE;
            round_r   <= 6'd0;
            w_valid_r <= 1'b0;
            done_r    <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                win_r[i] <= 32'h0000_0000;
            end
        end else if (load) begin
            state_r   <= ST_RUN;
            round_r   <= 6'd0;
            w_valid_r <= 1'b1;
            done_r    <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                win_r[i] <= block_in[(15 - i) * 32 +: 32];
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    w_valid_r <= 1'b0;
                    done_r    <= 1'b0;
                end
                ST_RUN: begin
                    if (advance) begin
                        if (round_r == 6'd63) begin
                            state_r   <= ST_DONE;
                            w_valid_r <= 1'b0;
                            done_r    <= 1'b1;
                        end else begin
                            for (int i = 0; i < 15; i++) begin
                                win_r[i] <= win_r[i + 1];
                            end
                            win_r[15] <= next_word_s;
                            round_r   <= round_r + 6'd1;
                            w_valid_r <= 1'b1;
                            done_r    <= 1'b0;
                        end
                    end else begin
                        w_valid_r <= 1'b1;
                        done_r    <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_r   <= ST_IDLE;
                    w_valid_r <= 1'b0;
                    done_r    <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    w_valid_r <= 1'b0;
                    done_r    <= 1'b0;
                end
            endcase
        end
    end

    assign w_out     = win_r[0];
    assign round_idx = round_r;
    assign w_valid   = w_valid_r;
    assign done      = done_r;

endmodule

// File: tb/tb_msg_schedule.sv
// Directed self-checking bench for msg_schedule using the "abc" padded block and
// the all-zero block, with hand-computed golden words.
module tb_msg_schedule;

    logic         clk;
    logic         n_rst;
    logic         load;
    logic [511:0] block_in;
    logic         advance;
    logic [31:0]  w_out;
    logic [5:0]   round_idx;
    logic         w_valid;
    logic         done;

    int checks;
    int failures;

    localparam logic [511:0] ABC_BLOCK  = {32'h6162_6380, 448'd0, 32'h0000_0018};
    localparam logic [511:0] ZERO_BLOCK = 512'd0;

    int          gold_t [7] = '{0, 15, 16, 17, 18, 19, 63};
    logic [31:0] gold_w [7] = '{32'h6162_6380, 32'h0000_0018, 32'h6162_6380, 32'h000F_0000,
                                32'h7DA8_6405, 32'h6000_03C6, 32'h12B1_EDEB};

    msg_schedule dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .load      (load),
        .block_in  (block_in),
        .advance   (advance),
        .w_out     (w_out),
        .round_idx (round_idx),
        .w_valid   (w_valid),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_block(input logic [511:0] blk);
        load     = 1'b1;
        block_in = blk;
        tick();
        load     = 1'b0;
        block_in = {16{$urandom()}};
    endtask

    // Advance held high from W0; checks golden words and the done pulse
    task automatic run_abc();
        advance = 1'b1;
        for (int t = 0; t < 64; t++) begin
            check_eq("abc_idx", 32'(round_idx), 32'(t));
            check_eq("abc_valid", 32'(w_valid), 32'd1);
            for (int g = 0; g < 7; g++) begin
                if (gold_t[g] == t) check_eq("abc_word", w_out, gold_w[g]);
            end
            tick();
        end
        advance = 1'b0;
        check_eq("abc_done", 32'(done), 32'd1);
        check_eq("abc_done_valid", 32'(w_valid), 32'd0);
    endtask

    task automatic run_zero_held();
        advance = 1'b1;
        for (int t = 0; t < 64; t++) begin
            check_eq("zero_idx", 32'(round_idx), 32'(t));
            check_eq("zero_word", w_out, 32'd0);
            check_eq("zero_nodone", 32'(done), 32'd0);
            tick();
        end
        advance = 1'b0;
        check_eq("zero_done", 32'(done), 32'd1);
    endtask

    initial begin
        int gap;
        checks   = 0;
        failures = 0;
        n_rst    = 1'b1;
        load     = 1'b0;
        advance  = 1'b0;
        block_in = ZERO_BLOCK;

        // Asynchronous reset between edges
        #2 n_rst = 1'b0;
        #1;
        check_eq("rst_w_out", w_out, 32'd0);
        check_eq("rst_idx", 32'(round_idx), 32'd0);
        check_eq("rst_valid", 32'(w_valid), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        tick();
        n_rst = 1'b1;
        tick();

        // Advance ignored in IDLE
        advance = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("idle_valid", 32'(w_valid), 32'd0);
            check_eq("idle_idx", 32'(round_idx), 32'd0);
        end
        advance = 1'b0;

        // abc golden run, then back to IDLE
        load_block(ABC_BLOCK);
        run_abc();
        tick();
        check_eq("post_done_clear", 32'(done), 32'd0);
        check_eq("post_done_valid", 32'(w_valid), 32'd0);

        // Zero block with random advance gaps
        load_block(ZERO_BLOCK);
        for (int k = 0; k < 64; k++) begin
            gap = int'($urandom_range(5, 0));
            for (int g = 0; g < gap; g++) begin
                tick();
                check_eq("gap_idx", 32'(round_idx), 32'(k));
                check_eq("gap_word", w_out, 32'd0);
                check_eq("gap_valid", 32'(w_valid), 32'd1);
                check_eq("gap_nodone", 32'(done), 32'd0);
            end
            advance = 1'b1;
            tick();
            advance = 1'b0;
            if (k < 63) begin
                check_eq("step_idx", 32'(round_idx), 32'(k + 1));
                check_eq("step_nodone", 32'(done), 32'd0);
            end else begin
                check_eq("gap_done", 32'(done), 32'd1);
            end
        end
        tick();
        check_eq("gap_done_once", 32'(done), 32'd0);

        // Reload at round 30 with advance also high
        load_block(ABC_BLOCK);
        advance = 1'b1;
        repeat (30) tick();
        check_eq("pre_reload_idx", 32'(round_idx), 32'd30);
        load     = 1'b1;
        block_in = ZERO_BLOCK;
        tick();
        load = 1'b0;
        check_eq("reload_idx", 32'(round_idx), 32'd0);
        check_eq("reload_word", w_out, 32'd0);
        check_eq("reload_valid", 32'(w_valid), 32'd1);
        check_eq("reload_nodone", 32'(done), 32'd0);
        run_zero_held();

        // Load in the DONE cycle
        load_block(ABC_BLOCK);
        check_eq("done_load_valid", 32'(w_valid), 32'd1);
        check_eq("done_load_idx", 32'(round_idx), 32'd0);
        check_eq("done_load_word", w_out, 32'h6162_6380);
        check_eq("done_load_nodone", 32'(done), 32'd0);

        // Reset pulse at round 40, then a clean golden run
        advance = 1'b1;
        repeat (40) tick();
        check_eq("pre_rst_idx", 32'(round_idx), 32'd40);
        #2 n_rst = 1'b0;
        #1;
        check_eq("midrst_w_out", w_out, 32'd0);
        check_eq("midrst_idx", 32'(round_idx), 32'd0);
        check_eq("midrst_valid", 32'(w_valid), 32'd0);
        check_eq("midrst_done", 32'(done), 32'd0);
        tick();
        n_rst   = 1'b1;
        advance = 1'b0;
        tick();
        check_eq("after_rst_done", 32'(done), 32'd0);
        check_eq("after_rst_valid", 32'(w_valid), 32'd0);
        load_block(ABC_BLOCK);
        run_abc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/msg_schedule.md
# msg_schedule

SHA-256 message schedule expander for the miner core. It sits between the block/nonce assembly logic and the compression datapath. It latches one 512-bit message block and then streams the 64 schedule words W0..W63 to the compression stage, one word per `advance` strobe. The strobe is issued by the core control unit during each compression round. A 16-word rolling window generates W16..W63 on the fly, so there is no 64-word array.

## Interface
- No parameters; word width fixed at 32, rounds fixed at 64.
- `clk`  in  1  clock; all state updates on the rising edge.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `load`  in  1  single-cycle strobe; captures `block_in` and starts a new schedule.
- `block_in`  in  512  message block, big-endian; W0 = `block_in[511:480]`, W15 = `block_in[31:0]`.
- `advance`  in  1  consume the current word and step to the next round.
- `w_out`  out  32  current schedule word W[`round_idx`], driven from a register.
- `round_idx`  out  6  index t of the word on `w_out`.
- `w_valid`  out  1  high while `w_out` holds a valid, unconsumed word.
- `done`  out  1  one-cycle pulse after W63 is consumed.

## Operation
- Storage: window registers win[0..15] (32 b each), with `w_out` = win[0]; a 6-bit round counter; a state register.
- States: IDLE, RUN, DONE.
- **IDLE**
  - `w_valid` = 0 and `advance` is ignored.
  - `load` sets win[i] = block word i, `round_idx` = 0, and moves to RUN.
- **RUN**
  - `w_valid` = 1.
  - `advance` with `round_idx` < 63:
    - win[i] <= win[i+1] for i = 0..14.
    - win[15] <= σ1(win[14]) + win[9] + σ0(win[1]) + win[0], mod 2^32, carries discarded.
    - `round_idx` increments by 1.
  - `advance` with `round_idx` = 63 moves to DONE. The window is not updated.
  - With no `advance`, all registers hold, for any number of cycles.
- **DONE**
  - `done` = 1 and `w_valid` = 0 for exactly one cycle, then the block moves to IDLE.
- σ0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
- σ1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
- Since win[k] holds W[t+k], the new word is W[t+16] = σ1(W[t+14]) + W[t+9] + σ0(W[t+1]) + W[t].
- `load` in any state, including RUN and DONE, restarts the schedule:
  - window reloaded, `round_idx` = 0, next state RUN;
  - `done` is suppressed in that cycle.
- `load` and `advance` in the same cycle: `load` wins and the `advance` is discarded.
- `block_in` is sampled only in the `load` cycle; it may change freely at any other time.

## Timing
- Reset values:
  - state IDLE, all win[] = 0, `round_idx` = 0;
  - `w_out` = 0, `w_valid` = 0, `done` = 0.
- Reset asserted mid-RUN aborts immediately to the reset values; no `done` is produced.
- Latency:
  - `load` at edge k: W0 is on `w_out` with `w_valid` = 1 after edge k.
  - `advance` at edge k: the next word is visible after edge k.
  - With `advance` held high continuously, W0..W63 appear on 64 consecutive cycles.
  - `done` is high in the cycle after the 64th `advance`.
- Minimum turnaround from `load` to `done`:
  - 65 cycles with `advance` held high, counting the `load` cycle;
  - a new `load` is accepted in the `done` cycle.
- Critical path: two σ functions plus a 4-input 32-bit add.
- `w_out` and `round_idx` are registered outputs; no combinational path runs from `advance` to `w_out`.

## Test plan
- Reset check: assert `n_rst` low asynchronously, between clock edges -> all outputs at the reset values immediately; `advance` pulses while IDLE leave `w_valid` = 0 and `round_idx` = 0.
- "abc" padded block (W0 = 0x61626380, W1..W14 = 0, W15 = 0x00000018), `advance` held high -> the following values, then `done` one cycle later:
  - `w_out` at t = 0, 15, 16, 17, 18, 19 = 0x61626380, 0x00000018, 0x61626380, 0x000F0000, 0x7DA86405, 0x600003C6;
  - W63 = 0x12B1EDEB.
- All-zero block, random `advance` gaps (0-5 idle cycles) -> every `w_out` = 0, `round_idx` increments only on `advance`, exactly one `done` after the 64th `advance`.
- `load` of the zero block at `round_idx` = 30 during an "abc" run, `advance` also high -> next cycle `round_idx` = 0, `w_out` = 0x00000000, no `done`; a full run follows.
- `load` issued in the DONE cycle -> next cycle `w_valid` = 1, `round_idx` = 0, W0 of the new block on `w_out`.
- Reset pulse at `round_idx` = 40 -> reset values, no `done`; a later "abc" `load` reproduces the golden sequence.
